// File: rtl/knn_topk_classifier.sv
// Streaming K-nearest-neighbour back end: running sorted top-K list, sequential vote, result handshake.
// Optional build macro KNN_TIE_NEAREST_EN: vote ties go to the class owning the nearer neighbour.
module knn_topk_classifier #(
   parameter int W           = 16,
   parameter int TYPE_W      = 3,
   parameter int K           = 7,
   parameter int NUM_CLASSES = 8,
   parameter int CNT_W       = $clog2(K+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_dist,
   input  logic [TYPE_W-1:0] in_type,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TYPE_W-1:0] out_type,
   output logic [CNT_W-1:0]  out_votes,
   output logic [W-1:0]      out_min_dist,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid is never withdrawn by the producer and data is held stable until the transfer.

   localparam int CLS_N = 2**TYPE_W;
   localparam int KI_W  = (K > 1) ? $clog2(K) : 1;
   localparam int RK_W  = $clog2(K+1);

   localparam logic [1:0] S_COLLECT = 2'd0;
   localparam logic [1:0] S_VOTE    = 2'd1;
   localparam logic [1:0] S_SCAN    = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   function automatic logic [CLS_N-1:0] votable_mask();
      logic [CLS_N-1:0] m;
      for (int j = 0; j < CLS_N; j++) m[j] = (j < NUM_CLASSES);
      return m;
   endfunction

   // Labels at or above NUM_CLASSES are kept in the list but never counted.
   localparam logic [CLS_N-1:0] VOTABLE = votable_mask();

   logic [1:0]        state_q, state_d;
   logic [W-1:0]      dist_q [K];
   logic [W-1:0]      dist_d [K];
   logic [TYPE_W-1:0] type_q [K];
   logic [TYPE_W-1:0] type_d [K];
   logic [K-1:0]      vld_q, vld_d;
   logic [CNT_W-1:0]  cnt_q [CLS_N];
   logic [CNT_W-1:0]  cnt_d [CLS_N];
   logic [KI_W-1:0]   vi_q, vi_d;
   logic [TYPE_W-1:0] sc_q, sc_d;
   logic [TYPE_W-1:0] best_type_q, best_type_d;
   logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
`ifdef KNN_TIE_NEAREST_EN
   logic [RK_W-1:0]   rank_q [CLS_N];
   logic [RK_W-1:0]   rank_d [CLS_N];
   logic [RK_W-1:0]   best_rank_q, best_rank_d;
`endif

   logic [K-1:0]      gt;
   logic              accept;
   logic [TYPE_W-1:0] cur_type;
   logic              take;

   // gt[i]: new sample belongs at or above slot i; monotonic because the list is sorted
   // and invalid slots sit at the tail. Strict compare keeps equal distances stable.
   always_comb begin
      for (int i = 0; i < K; i++) gt[i] = !vld_q[i] || (dist_q[i] > in_dist);
   end

   assign accept       = in_valid && (state_q == S_COLLECT);
   assign in_ready     = (state_q == S_COLLECT);
   assign out_valid    = (state_q == S_DONE);
   assign busy         = (state_q != S_COLLECT);
   assign out_type     = best_type_q;
   assign out_votes    = best_cnt_q;
   assign out_min_dist = dist_q[0];
   assign dbg_state    = state_q;
   assign cur_type     = type_q[vi_q];

   always_comb begin
      state_d     = state_q;
      dist_d      = dist_q;
      type_d      = type_q;
      vld_d       = vld_q;
      cnt_d       = cnt_q;
      vi_d        = vi_q;
      sc_d        = sc_q;
      best_type_d = best_type_q;
      best_cnt_d  = best_cnt_q;
      take        = 1'b0;
`ifdef KNN_TIE_NEAREST_EN
      rank_d      = rank_q;
      best_rank_d = best_rank_q;
`endif
      case (state_q)
         S_COLLECT: begin
            if (accept) begin
               if (gt[0]) begin
                  dist_d[0] = in_dist;
                  type_d[0] = in_type;
                  vld_d[0]  = 1'b1;
               end
               for (int i = 1; i < K; i++) begin
                  if (gt[i]) begin
                     if (gt[i-1]) begin
                        dist_d[i] = dist_q[i-1];
                        type_d[i] = type_q[i-1];
                        vld_d[i]  = vld_q[i-1];
                     end else begin
                        dist_d[i] = in_dist;
                        type_d[i] = in_type;
                        vld_d[i]  = 1'b1;
                     end
                  end
               end
               if (in_last) begin
                  state_d     = S_VOTE;
                  vi_d        = '0;
                  best_type_d = '0;
                  best_cnt_d  = '0;
`ifdef KNN_TIE_NEAREST_EN
                  best_rank_d = RK_W'(K);
                  for (int c = 0; c < CLS_N; c++) rank_d[c] = RK_W'(K);
`endif
               end
            end
         end
         S_VOTE: begin
            if (vld_q[vi_q] && VOTABLE[cur_type]) begin
               cnt_d[cur_type] = cnt_q[cur_type] + CNT_W'(1);
`ifdef KNN_TIE_NEAREST_EN
               // Slots are visited nearest first, so the first hit is the nearest rank.
               if (rank_q[cur_type] == RK_W'(K)) rank_d[cur_type] = RK_W'(vi_q);
`endif
            end
            if (vi_q == KI_W'(K-1)) begin
               state_d = S_SCAN;
               sc_d    = '0;
            end else begin
               vi_d = vi_q + KI_W'(1);
            end
         end
         S_SCAN: begin
            take = cnt_q[sc_q] > best_cnt_q;
`ifdef KNN_TIE_NEAREST_EN
            if ((cnt_q[sc_q] == best_cnt_q) && (cnt_q[sc_q] != '0) &&
                (rank_q[sc_q] < best_rank_q)) take = 1'b1;
            if (take) best_rank_d = rank_q[sc_q];
`endif
            if (take) begin
               best_type_d = sc_q;
               best_cnt_d  = cnt_q[sc_q];
            end
            if (sc_q == TYPE_W'(NUM_CLASSES-1)) state_d = S_DONE;
            else sc_d = sc_q + TYPE_W'(1);
         end
         default: begin
            if (out_ready) begin
               state_d = S_COLLECT;
               vld_d   = '0;
               for (int i = 0; i < K; i++) begin
                  dist_d[i] = '1;
                  type_d[i] = '0;
               end
               for (int c = 0; c < CLS_N; c++) cnt_d[c] = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_COLLECT;
         vld_q       <= '0;
         vi_q        <= '0;
         sc_q        <= '0;
         best_type_q <= '0;
         best_cnt_q  <= '0;
         for (int i = 0; i < K; i++) begin
            dist_q[i] <= '1;
            type_q[i] <= '0;
         end
         for (int c = 0; c < CLS_N; c++) cnt_q[c] <= '0;
`ifdef KNN_TIE_NEAREST_EN
         best_rank_q <= RK_W'(K);
         for (int c = 0; c < CLS_N; c++) rank_q[c] <= RK_W'(K);
`endif
      end else begin
         state_q     <= state_d;
         vld_q       <= vld_d;
         vi_q        <= vi_d;
         sc_q        <= sc_d;
         best_type_q <= best_type_d;
         best_cnt_q  <= best_cnt_d;
         for (int i = 0; i < K; i++) begin
            dist_q[i] <= dist_d[i];
            type_q[i] <= type_d[i];
         end
         for (int c = 0; c < CLS_N; c++) cnt_q[c] <= cnt_d[c];
`ifdef KNN_TIE_NEAREST_EN
         best_rank_q <= best_rank_d;
         for (int c = 0; c < CLS_N; c++) rank_q[c] <= rank_d[c];
`endif
      end
   end

endmodule
